// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU and the ACC state.
package muldiv_pkg;

    localparam int unsigned DIV_ITERS_DEFAULT = 32;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

`ifdef MULDIV_MADD_EN
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, ACC} state_e;
`else
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
`endif

    function automatic logic op_valid(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_valid = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_valid = 1'b1;
`endif
            default: op_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request and HI/LO result bundle of the multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        ex_adv;
    logic        flush;
    logic        isbusy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, ex_adv, flush,
        input  isbusy, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, ex_adv, flush,
        output isbusy, hi, lo
    );
endinterface

// File: rtl/div_iter.sv
// Unsigned restoring divider core: one quotient bit per step, Iters steps after load.
// `done` is high during the final step, so results are valid on the following cycle.
module div_iter #(
    parameter int unsigned Width = 32,
    parameter int unsigned Iters = Width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [Width-1:0] dividend,
    input  logic [Width-1:0] divisor,
    output logic [Width-1:0] quotient,
    output logic [Width-1:0] remainder,
    output logic             done
);
    localparam int unsigned CntW = $clog2(Iters + 1);

    logic [Width-1:0] dvs, quo, rem;
    logic [CntW-1:0]  cnt;
    logic [Width:0]   shifted, diff;

    always_comb begin
        shifted = {rem, quo[Width-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvs <= '0;
            quo <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (load) begin
            dvs <= divisor;
            quo <= dividend;
            rem <= '0;
            cnt <= CntW'(Iters);
        end else if (step && cnt != '0) begin
            cnt <= cnt - CntW'(1);
            // A borrow means the trial subtraction failed: keep the shifted remainder.
            if (!diff[Width]) begin
                rem <= diff[Width-1:0];
                quo <= {quo[Width-2:0], 1'b1};
            end else begin
                rem <= shifted[Width-1:0];
                quo <= {quo[Width-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign done      = step && (cnt == CntW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: MULT/MULTU (2 cycles), DIV/DIVU (DIV_ITERS+2), MTHI/MTLO (1).
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU through an extra ACC cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    state_e      state, state_next;
    logic        taken, acc, is_mul_op, is_div_op, sdiv;
    logic [31:0] a, b, mag_a, mag_b, quo, rem, hi, lo;
    logic        sgn, q_neg, r_neg;
    logic        div_load, div_step, div_done;
    logic [63:0] product;
`ifdef MULDIV_MADD_EN
    logic        is_madd, is_msub;
    logic [63:0] prod_q;
`endif

    always_comb begin
        is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef MULDIV_MADD_EN
        is_mul_op = is_mul_op || (bus.op == OP_MADD) || (bus.op == OP_MADDU)
                    || (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
`endif
    end

    assign is_div_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign sdiv      = (bus.op == OP_DIV);
    assign acc       = bus.start & ~bus.flush & ~taken & (state == IDLE) & op_valid(bus.op);
    assign mag_a     = (sdiv && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
    assign mag_b     = (sdiv && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
    assign product   = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};

    // Stops a stalled EX instruction from issuing again until EX advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             taken <= 1'b0;
        else if (bus.ex_adv) taken <= 1'b0;
        else if (acc)        taken <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (acc && is_mul_op)      state_next = MUL;
                else if (acc && is_div_op) state_next = DIV;
            end
`ifdef MULDIV_MADD_EN
            MUL:     state_next = (is_madd || is_msub) ? ACC : IDLE;
            ACC:     state_next = IDLE;
`else
            MUL:     state_next = IDLE;
`endif
            DIV:     if (div_done) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.isbusy = acc | (state != IDLE);
        div_load   = acc & is_div_op;
        div_step   = (state == DIV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            sgn   <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
`ifdef MULDIV_MADD_EN
            is_madd <= 1'b0;
            is_msub <= 1'b0;
`endif
        end else if (acc) begin
            a     <= bus.rs_val;
            b     <= bus.rt_val;
            sgn   <= (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
            q_neg <= sdiv & (bus.rs_val[31] ^ bus.rt_val[31]);
            r_neg <= sdiv & bus.rs_val[31];
`ifdef MULDIV_MADD_EN
            is_madd <= (bus.op == OP_MADD) || (bus.op == OP_MADDU);
            is_msub <= (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
`endif
        end
    end

    div_iter #(
        .Width (32),
        .Iters (DIV_ITERS)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

`ifdef MULDIV_MADD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               prod_q <= '0;
        else if (state == MUL) prod_q <= product;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (acc && bus.op == OP_MTHI) hi <= bus.rs_val;
            if (acc && bus.op == OP_MTLO) lo <= bus.rs_val;
            case (state)
`ifdef MULDIV_MADD_EN
                MUL: if (!is_madd && !is_msub) {hi, lo} <= product;
                ACC: {hi, lo} <= is_msub ? ({hi, lo} - prod_q) : ({hi, lo} + prod_q);
`else
                MUL: {hi, lo} <= product;
`endif
                FIX: begin
                    lo <= q_neg ? -quo : quo;
                    hi <= r_neg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi = hi;
    assign bus.lo = lo;

endmodule
